// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit feeder: data width, the feeder FSM
// state encoding and the reset values of the feeder's registered outputs.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } fsm_state_t;

  localparam fsm_state_t             RST_STATE   = IDLE;
  localparam logic                   RST_TX_EN   = 1'b0;
  localparam logic [UART_DATA_W-1:0] RST_TX_DATA = 8'h00;
  localparam logic                   RST_ACK_ERR = 1'b0;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with wrap-bit pointers. Full when the pointers differ only
// in their MSB, empty when they are equal. Flush returns both pointers to zero
// and wins over a push or pop in the same cycle.
// Ports:
//   clock, reset      clock, asynchronous active-low reset
//   i_push/i_push_data write request (ignored while full or flushing)
//   i_pop             read request (ignored while empty or flushing)
//   i_flush           synchronous clear of the contents
//   o_head            entry at the read pointer (valid when !o_empty)
//   o_count           occupancy, 0..DEPTH
//   o_full, o_empty   status flags
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // Read/write pointer update; flush discards everything including a same-cycle push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_INC;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_INC;
      end
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Buffers bytes from a valid/ready producer and hands them one at a time to the
// UART core using its en/busy handshake. After each start pulse the feeder
// waits up to ACK_TIMEOUT cycles for busy to rise; if it never does the byte is
// dropped and the sticky ack_err flag is raised.
// Ports:
//   clock, reset            clock, asynchronous active-low reset
//   in_valid/in_data/in_ready  producer stream (in_ready = !full)
//   flush                   clears queued bytes and ack_err; in-flight byte completes
//   uart_tx_en/uart_tx_data one-cycle start pulse and byte to the UART core
//   uart_tx_busy            UART core transmitting
//   fifo_count              queued bytes
//   idle                    queue empty and nothing in flight
//   ack_err                 sticky timeout flag
// -----------------------------------------------------------------------------
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [UART_DATA_W-1:0] in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   uart_tx_en,
  output logic [UART_DATA_W-1:0] uart_tx_data,
  input  logic                   uart_tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   idle,
  output logic                   ack_err
);

  localparam int            TW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_INC  = TW'(1);

  fsm_state_t             r_state;
  fsm_state_t             w_next_state;
  logic                   r_tx_en;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic [TW-1:0]          r_timer;
  logic                   r_ack_err;
  logic                   w_issue;
  logic                   w_timeout;
  logic [UART_DATA_W-1:0] w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (in_valid),
    .i_push_data (in_data),
    .i_pop       (w_issue),
    .i_flush     (flush),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Next-state logic. An issue is held off during a flush so the entry being
  // discarded is never also sent.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !uart_tx_busy && !flush) begin
          w_issue      = 1'b1;
          w_next_state = WAIT_ACK;
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT_ACK: begin
        if (uart_tx_busy) begin
          w_next_state = WAIT_DONE;
        end else if (r_timer == TIMER_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_next_state = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = WAIT_DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, start pulse, held byte, acknowledge timer and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= RST_STATE;
      r_tx_en   <= RST_TX_EN;
      r_tx_data <= RST_TX_DATA;
      r_timer   <= '0;
      r_ack_err <= RST_ACK_ERR;
    end else begin
      r_state <= w_next_state;
      r_tx_en <= w_issue;
      if (w_issue) begin
        r_tx_data <= w_head;
      end
      // Timer starts at zero in the pulse cycle, so the timeout decision falls
      // ACK_TIMEOUT-1 cycles later and ack_err is visible ACK_TIMEOUT cycles after the pulse.
      if (w_issue) begin
        r_timer <= '0;
      end else if ((r_state == WAIT_ACK) && !w_timeout) begin
        r_timer <= r_timer + TIMER_INC;
      end
      if (flush) begin
        r_ack_err <= 1'b0;
      end else if (w_timeout) begin
        r_ack_err <= 1'b1;
      end
    end
  end

  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign ack_err      = r_ack_err;
  assign in_ready     = !w_full;
  assign fifo_count   = w_count;
  assign idle         = w_empty && (r_state == IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
// Self-checking bench for uart_tx_feeder. The reference is a byte queue holding
// everything accepted but not yet sent; every start pulse must carry the queue
// head, occupancy and in_ready are compared every cycle, and a small UART-core
// model answers pulses with a busy window of programmable length.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       flush = 1'b0;
  logic       in_ready;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic [4:0] fifo_count;
  logic       idle;
  logic       ack_err;

  // UART core model controls
  logic manual   = 1'b0;
  logic man_busy = 1'b0;
  logic respond  = 1'b1;
  int   busy_len = 10;
  logic m_busy;
  int   m_left;

  // Reference model state
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         n_push = 0;
  logic [7:0] q[$];
  logic [7:0] pulse_data[$];
  int         pulse_tick[$];
  int         ack_rise_tick = -1;
  logic       prev_en = 1'b0;
  logic       prev_ack = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       f;
    int         exp_cnt;
    logic       exp_rdy;
    logic       exp_idle;
  } vec_t;
  vec_t tbl[7];

  always #5 clock = ~clock;

  assign uart_tx_busy = manual ? man_busy : m_busy;

  uart_tx_feeder #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .flush        (flush),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .fifo_count   (fifo_count),
    .idle         (idle),
    .ack_err      (ack_err)
  );

  // UART core: busy rises the cycle after a pulse and lasts busy_len cycles.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_left <= 0;
    end else if (m_busy) begin
      if (m_left <= 1) m_busy <= 1'b0;
      else m_left <= m_left - 1;
    end else if (uart_tx_en && respond) begin
      m_busy <= 1'b1;
      m_left <= busy_len;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: update the reference at the edge, then check at the falling edge.
  task automatic tick();
    logic       acc;
    logic       pf;
    logic [7:0] pd;
    logic [7:0] exp_b;
    pf  = flush;
    pd  = in_data;
    acc = in_valid && !flush && (q.size() < DEPTH);
    @(posedge clock);
    if (pf) q.delete();
    if (acc) begin
      q.push_back(pd);
      n_push++;
    end
    @(negedge clock);
    cyc++;
    if (uart_tx_en) begin
      chk("no_back_to_back", 32'(prev_en), 32'd0);
      chk("pulse_while_busy", 32'(uart_tx_busy), 32'd0);
      chk("pulse_has_entry", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        exp_b = q.pop_front();
        chk("pulse_data", 32'(uart_tx_data), 32'(exp_b));
      end
      pulse_data.push_back(uart_tx_data);
      pulse_tick.push_back(cyc);
    end else begin
      chk("data_hold", 32'(uart_tx_data), 32'(prev_data));
    end
    if (ack_err && !prev_ack) ack_rise_tick = cyc;
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    prev_en   = uart_tx_en;
    prev_data = uart_tx_data;
    prev_ack  = ack_err;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    i = 0;
    while (i < budget && idle !== 1'b1) begin
      tick();
      i++;
    end
    chk(nm, 32'(idle), 32'd1);
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    #1;
    chk("rst_tx_en", 32'(uart_tx_en), 32'd0);
    chk("rst_tx_data", 32'(uart_tx_data), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    q.delete();
    prev_en   = 1'b0;
    prev_data = 8'h00;
    prev_ack  = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int base;
    int base_push;
    int t0;

    tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h33, 1'b1, 0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 8'h44, 1'b0, 1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h55, 1'b0, 2, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1};

    #2;
    do_reset();

    // Single byte: pulse two cycles after the push, idle once busy falls.
    manual = 1'b0; respond = 1'b1; busy_len = 10;
    base = pulse_data.size();
    t0 = cyc;
    push(8'h55);
    chk("t1_no_early_pulse", 32'(uart_tx_en), 32'd0);
    tick();
    chk("t1_pulse", 32'(uart_tx_en), 32'd1);
    chk("t1_data", 32'(uart_tx_data), 32'h55);
    wait_idle(40, "t1_idle");
    chk("t1_pulse_count", 32'(pulse_data.size() - base), 32'd1);
    if (pulse_tick.size() > base) chk("t1_latency", 32'(pulse_tick[base] - t0), 32'd2);

    // Vector table with busy held high: push / flush interaction.
    manual = 1'b1; man_busy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      flush    = tbl[i].f;
      tick();
      chk("tbl_count", 32'(fifo_count), 32'(tbl[i].exp_cnt));
      chk("tbl_ready", 32'(in_ready), 32'(tbl[i].exp_rdy));
      chk("tbl_idle", 32'(idle), 32'(tbl[i].exp_idle));
    end
    in_valid = 1'b0; flush = 1'b0;

    // Fill to DEPTH while busy, then drain in order.
    base = pulse_data.size();
    for (int i = 1; i <= 16; i++) push(8'(i));
    chk("t2_full_count", 32'(fifo_count), 32'd16);
    chk("t2_not_ready", 32'(in_ready), 32'd0);
    push(8'h99);
    chk("t2_overflow_count", 32'(fifo_count), 32'd16);
    manual = 1'b0; respond = 1'b1; busy_len = 3;
    wait_idle(300, "t2_idle");
    chk("t2_pulse_count", 32'(pulse_data.size() - base), 32'd16);
    if (pulse_data.size() >= base + 16)
      for (int i = 0; i < 16; i++) chk("t2_order", 32'(pulse_data[base + i]), 32'(i + 1));

    // Simultaneous push and pop at count 5, then 20 bytes total while draining.
    manual = 1'b1; man_busy = 1'b1;
    base = pulse_data.size();
    base_push = n_push;
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    chk("t3_count5", 32'(fifo_count), 32'd5);
    manual = 1'b0; respond = 1'b1; busy_len = 2;
    push(8'h30);
    chk("t3_count_hold", 32'(fifo_count), 32'd5);
    chk("t3_pop", 32'(uart_tx_en), 32'd1);
    for (int i = 0; i < 400 && (n_push - base_push) < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_idle(300, "t3_idle");
    chk("t3_pulse_count", 32'(pulse_data.size() - base), 32'd20);

    // Core never acknowledges: timeout, byte lost, next byte still issues.
    respond = 1'b0;
    ack_rise_tick = -1;
    base = pulse_data.size();
    push(8'hA1);
    push(8'hA2);
    wait_idle(60, "t4_idle");
    chk("t4_pulse_count", 32'(pulse_data.size() - base), 32'd2);
    if (pulse_tick.size() > base) begin
      chk("t4_first", 32'(pulse_data[base]), 32'hA1);
      chk("t4_ack_latency", 32'(ack_rise_tick - pulse_tick[base]), 32'(ACK_TIMEOUT));
    end
    chk("t4_ack_err", 32'(ack_err), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_ack", 32'(ack_err), 32'd0);
    chk("t4_flush_count", 32'(fifo_count), 32'd0);

    // Flush during WAIT_DONE with 3 queued; same-cycle push of 0xAA dropped.
    respond = 1'b1; busy_len = 8;
    base = pulse_data.size();
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    tick(); tick();
    chk("t5_queued", 32'(fifo_count), 32'd3);
    chk("t5_busy", 32'(uart_tx_busy), 32'd1);
    in_valid = 1'b1; in_data = 8'hAA; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("t5_flushed", 32'(fifo_count), 32'd0);
    wait_idle(40, "t5_idle");
    for (int i = 0; i < 10; i++) tick();
    chk("t5_pulse_count", 32'(pulse_data.size() - base), 32'd1);

    // Reset in WAIT_DONE with 4 queued.
    busy_len = 8;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5);
    tick();
    chk("t6_queued", 32'(fifo_count), 32'd4);
    chk("t6_busy", 32'(uart_tx_busy), 32'd1);
    do_reset();
    base = pulse_data.size();
    for (int i = 0; i < 10; i++) tick();
    chk("t6_no_pulse", 32'(pulse_data.size() - base), 32'd0);
    push(8'h77);
    wait_idle(40, "t6_idle");
    chk("t6_pulse_count", 32'(pulse_data.size() - base), 32'd1);
    if (pulse_data.size() > base) chk("t6_data", 32'(pulse_data[base]), 32'h77);

    // Randomised traffic with occasional flushes and varying busy lengths.
    respond = 1'b1; manual = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = 8'($urandom);
      flush    = ($urandom_range(0, 19) == 0);
      busy_len = $urandom_range(1, 4);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
    wait_idle(200, "rnd_idle");
    chk("rnd_ack_err", 32'(ack_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Buffered byte source that drives the transmit side of the UART core (uart_tx_en / uart_tx_data / uart_tx_busy). It accepts bytes from a valid/ready stream into a FIFO and issues them to the UART core one at a time, obeying the core's busy handshake. It sits between on-chip producers and the UART core, as the client end of the core's TX interface.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
ACK_TIMEOUT, 4, cycles to wait for uart_tx_busy to rise after a uart_tx_en pulse before the byte is dropped

Ports:
clock  input  1  single clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  producer has a byte
in_data  input  8  producer byte
in_ready  output  1  FIFO can accept; equals !full
flush  input  1  synchronous flush of FIFO contents
uart_tx_en  output  1  one-cycle start pulse to the UART core
uart_tx_data  output  8  byte to the UART core; held stable from the pulse until busy falls
uart_tx_busy  input  1  UART core transmitting
fifo_count  output  clog2(DEPTH)+1  current occupancy
idle  output  1  FIFO empty and FSM in IDLE
ack_err  output  1  sticky; set on ACK timeout, cleared by flush

Behaviour:
- Reset (reset=0, async): FIFO empty; rd/wr pointers 0; FSM=IDLE; uart_tx_en=0, uart_tx_data=0x00, in_ready=1, fifo_count=0, idle=1, ack_err=0.
- Write: in_valid && in_ready at a rising edge pushes in_data. fifo_count updates the next cycle.
- Pointers carry one extra wrap bit; full when the pointers differ only in the MSB; empty when they are equal.
- Simultaneous push and pop: count unchanged. A push while full is impossible because in_ready=0.
- FSM states:
  - IDLE: if FIFO non-empty and uart_tx_busy=0, pop the head into uart_tx_data, assert uart_tx_en for exactly one cycle, go to WAIT_ACK. Latency from the first push into an empty FIFO to uart_tx_en=1 is 2 cycles (1 for the write, 1 for the issue).
  - WAIT_ACK: a timer counts cycles. If uart_tx_busy=1, go to WAIT_DONE. If the timer reaches ACK_TIMEOUT, set ack_err and go to IDLE; the byte is lost.
  - WAIT_DONE: wait for uart_tx_busy=0, then go to IDLE.
  - The minimum gap between consecutive pulses is therefore busy-fall + 1 cycle.
- uart_tx_en is never asserted while uart_tx_busy=1, and never on two consecutive cycles.
- uart_tx_data changes only in the cycle a pulse is issued.
- flush=1:
  - Empties the FIFO next cycle and clears ack_err.
  - Does not abort an in-flight byte; the FSM completes WAIT_ACK/WAIT_DONE normally.
  - A push in the same cycle as flush is discarded.
- uart_tx_busy=1 while in IDLE (e.g. asserted externally): no issue until it falls.
- Reset mid-operation: all state is cleared immediately, including the pending pulse. The byte held in the UART core is not the feeder's concern.
- idle = empty && state==IDLE.

Decomposition:
- Shared package uart_pkg: UART_DATA_W=8 constant, fsm state enum (IDLE, WAIT_ACK, WAIT_DONE), reset-value constants.
- One sub-module, uart_sync_fifo: parameterised width/depth, push/pop/flush, count/full/empty.
- The feeder FSM and timer live in the top module.

Test Plan:
1. Reset, then push 0x55 with a UART model that raises busy 1 cycle after the pulse and holds it 10 cycles -> uart_tx_en pulses once, 2 cycles after the push, with uart_tx_data=0x55; idle=1 after busy falls.
2. Push 0x01..0x10 back-to-back (DEPTH=16) while busy is held high -> in_ready=0 after the 16th byte and fifo_count=16. Then release busy -> 16 pulses in order 0x01..0x10, each only after busy fell.
3. Push and pop in the same cycle at count=5 -> fifo_count stays 5. Push 20 bytes total while draining -> no loss, correct order, pointer wrap exercised.
4. UART model never raises busy -> ack_err=1 exactly ACK_TIMEOUT cycles after the pulse, FSM returns to IDLE, and the next byte issues. Then flush -> ack_err=0 and fifo_count=0.
5. Flush while in WAIT_DONE with 3 bytes queued -> current byte completes, no further pulses, fifo_count=0. A same-cycle push of 0xAA is discarded.
6. Assert reset low mid-WAIT_DONE with 4 bytes queued -> all outputs take reset values immediately; after release, no uart_tx_en until a new push.
